rtc_hms_core: RTL and testbench

- Time-of-day counter that keeps hh:mm:ss in packed BCD and sits directly downstream of the 1 Hz divider.
- Consumes the divider's clk_hz square wave as a data input. It is synchronized and edge-detected in the clki domain and never used as a clock.
- Provides a run/set-time mode FSM driven by pre-debounced single-cycle button pulses.
- Outputs feed the 7-segment display mux.

---
 rtl/rtc_hms_core.sv | 83 ++++++++
 tb/tb_rtc_hms_core.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/rtc_hms_core.sv
// rtc_hms_core: BCD hh:mm:ss time-of-day counter fed by a synchronized 1 Hz strobe, with run/set-time mode FSM.
// Defining RTC_ALARM_EN adds al_hh/al_mm inputs and a registered hh:mm alarm output.
module rtc_hms_core #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] INIT_HH     = 8'h00,
  parameter logic [7:0] INIT_MM     = 8'h00
) (
  input  logic       clki,
  input  logic       rst,
  input  logic       clk_hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [7:0] hh_bcd,
  output logic [7:0] mm_bcd,
  output logic [7:0] ss_bcd,
  output logic [1:0] mode,
  output logic       sec_tick
`ifdef RTC_ALARM_EN
  ,
  input  logic [7:0] al_hh,
  input  logic [7:0] al_mm,
  output logic       alarm
`endif
);
  typedef enum logic [1:0] {RUN = 2'b00, SET_HH = 2'b01, SET_MM = 2'b10} mode_e;
  mode_e                  mode_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic [7:0]             hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
  logic                   run, inc_ok, run_tick;
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
    return (v == top) ? 8'h00 : (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction
  assign sec_tick = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign run      = mode_q == RUN;
  assign inc_ok   = btn_inc & ~btn_mode;
  assign run_tick = run & sec_tick;
  // all three carries resolve from current-state compares so 23:59:59 wraps in one edge
  always_comb begin
    ss_d = (mode_q == SET_MM && btn_mode) ? 8'h00 : run_tick ? bcd_inc(ss_q, 8'h59) : ss_q;
    mm_d = ((mode_q == SET_MM && inc_ok) || (run_tick && ss_q == 8'h59)) ? bcd_inc(mm_q, 8'h59) : mm_q;
    hh_d = ((mode_q == SET_HH && inc_ok) || (run_tick && ss_q == 8'h59 && mm_q == 8'h59)) ?
           bcd_inc(hh_q, 8'h23) : hh_q;
  end
  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      mode_q <= RUN;
      hh_q   <= INIT_HH;
      mm_q   <= INIT_MM;
      ss_q   <= 8'h00;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], clk_hz};
      hist_q <= sync_q[SYNC_STAGES-1];
      mode_q <= btn_mode ? (mode_q == RUN ? SET_HH : mode_q == SET_HH ? SET_MM : RUN) :
                (mode_q == SET_HH || mode_q == SET_MM) ? mode_q : RUN;
      hh_q   <= hh_d;
      mm_q   <= mm_d;
      ss_q   <= ss_d;
    end
  end
  assign hh_bcd = hh_q;
  assign mm_bcd = mm_q;
  assign ss_bcd = ss_q;
  assign mode   = mode_q;
`ifdef RTC_ALARM_EN
  logic alarm_q, supp_q, hit, dismiss;
  assign hit     = run & (hh_q == al_hh) & (mm_q == al_mm);
  assign dismiss = btn_inc & run & alarm_q;
  // snooze lasts until the displayed minute moves on
  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      alarm_q <= 1'b0;
      supp_q  <= 1'b0;
    end else begin
      alarm_q <= hit & ~supp_q & ~dismiss;
      supp_q  <= (mm_d != mm_q || hh_d != hh_q) ? 1'b0 : (supp_q | dismiss);
    end
  end
  assign alarm = alarm_q;
`endif
endmodule

// File: tb/tb_rtc_hms_core.sv
// tb_rtc_hms_core: table-driven set/run vectors plus hand-timed tick, wrap and reset sequences.
module tb_rtc_hms_core;
  logic clki = 1'b0, rst = 1'b1, clk_hz = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0;
  logic [7:0] hh_bcd, mm_bcd, ss_bcd;
  logic [1:0] mode;
  logic sec_tick;
`ifdef RTC_ALARM_EN
  logic [7:0] al_hh = 8'h07, al_mm = 8'h30;
  logic alarm;
`endif
  int n_run = 0, n_fail = 0;
  typedef struct {
    logic bm, bi, tk;
    logic [7:0] hh, mm, ss;
    logic [1:0] md;
  } vec_t;
  vec_t vecs[$];
  rtc_hms_core dut (
    .clki(clki), .rst(rst), .clk_hz(clk_hz), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .hh_bcd(hh_bcd), .mm_bcd(mm_bcd), .ss_bcd(ss_bcd), .mode(mode), .sec_tick(sec_tick)
`ifdef RTC_ALARM_EN
    , .al_hh(al_hh), .al_mm(al_mm), .alarm(alarm)
`endif
  );
  always #10 clki = ~clki;
  function automatic logic [7:0] bcd(input int n);
    logic [3:0] t, o;
    t = 4'(n / 10);
    o = 4'(n % 10);
    return {t, o};
  endfunction
  function automatic void add(input logic bm, bi, tk, input int h, m, s, md);
    vec_t v;
    v.bm = bm; v.bi = bi; v.tk = tk;
    v.hh = bcd(h); v.mm = bcd(m); v.ss = bcd(s); v.md = 2'(md);
    vecs.push_back(v);
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [31:0] now();
    return {6'd0, hh_bcd, mm_bcd, ss_bcd, mode};
  endfunction
  function automatic logic [31:0] tv(input logic [7:0] h, m, s, input logic [1:0] md);
    return {6'd0, h, m, s, md};
  endfunction
  task automatic cyc();
    @(posedge clki);
    #1;
  endtask
  task automatic press(input logic bm, input logic bi);
    btn_mode = bm;
    btn_inc = bi;
    cyc();
    btn_mode = 1'b0;
    btn_inc = 1'b0;
  endtask
  task automatic do_tick();
    clk_hz = 1'b1;
    repeat (4) cyc();
    clk_hz = 1'b0;
    repeat (4) cyc();
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    add(1, 0, 0, 0, 0, 1, 1);
    add(0, 0, 1, 0, 0, 1, 1);
    for (int i = 1; i <= 25; i++) add(0, 1, 0, i % 24, 0, 1, 1);
    add(1, 1, 0, 1, 0, 1, 2);
    for (int i = 1; i <= 59; i++) add(0, 1, 0, 1, i, 1, 2);
    add(0, 1, 0, 1, 0, 1, 2);
    add(0, 0, 1, 1, 0, 1, 2);
    add(1, 0, 0, 1, 0, 0, 0);
    add(0, 0, 1, 1, 0, 1, 0);
    add(0, 1, 0, 1, 0, 1, 0);
    add(1, 0, 0, 1, 0, 1, 1);
    for (int i = 2; i <= 23; i++) add(0, 1, 0, i, 0, 1, 1);
    add(1, 0, 0, 23, 0, 1, 2);
    for (int i = 1; i <= 59; i++) add(0, 1, 0, 23, i, 1, 2);
    add(1, 0, 0, 23, 59, 0, 0);
    repeat (3) cyc();
    chk("in_reset", now(), 32'd0);
    chk("in_reset_tick", {31'd0, sec_tick}, 32'd0);
    rst = 1'b0;
    cyc();
    chk("after_reset", now(), 32'd0);
    clk_hz = 1'b1;
    cyc();
    chk("lat_e0_tick", {31'd0, sec_tick}, 32'd0);
    cyc();
    chk("lat_e1_tick", {31'd0, sec_tick}, 32'd1);
    chk("lat_e1_ss", {24'd0, ss_bcd}, 32'h00);
    cyc();
    chk("lat_e2_tick", {31'd0, sec_tick}, 32'd0);
    chk("lat_e2_ss", {24'd0, ss_bcd}, 32'h01);
    clk_hz = 1'b0;
    repeat (4) cyc();
    chk("single_tick", now(), tv(8'h00, 8'h00, 8'h01, 2'd0));
    foreach (vecs[i]) begin
      if (vecs[i].tk) do_tick();
      else press(vecs[i].bm, vecs[i].bi);
      chk($sformatf("vec%0d", i), now(), tv(vecs[i].hh, vecs[i].mm, vecs[i].ss, vecs[i].md));
    end
    repeat (59) do_tick();
    chk("at_235959", now(), tv(8'h23, 8'h59, 8'h59, 2'd0));
    clk_hz = 1'b1;
    cyc();
    cyc();
    chk("wrap_pre", now(), tv(8'h23, 8'h59, 8'h59, 2'd0));
    cyc();
    chk("wrap_edge", now(), tv(8'h00, 8'h00, 8'h00, 2'd0));
    clk_hz = 1'b0;
    repeat (4) cyc();
    clk_hz = 1'b1;
    cyc();
    cyc();
    btn_mode = 1'b1;
    cyc();
    btn_mode = 1'b0;
    chk("tick_and_mode", now(), tv(8'h00, 8'h00, 8'h01, 2'd1));
    clk_hz = 1'b0;
    repeat (4) cyc();
    clk_hz = 1'b1;
    cyc();
    cyc();
    chk("tick_in_set", {31'd0, sec_tick}, 32'd1);
    cyc();
    chk("frozen_in_set", now(), tv(8'h00, 8'h00, 8'h01, 2'd1));
    clk_hz = 1'b0;
    repeat (4) cyc();
    press(1, 0);
    press(0, 1);
    press(0, 1);
    chk("pre_reset", now(), tv(8'h00, 8'h02, 8'h01, 2'd2));
    btn_inc = 1'b1;
    @(negedge clki);
    rst = 1'b1;
    #1;
    chk("async_reset", now(), 32'd0);
    btn_inc = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();
    cyc();
    chk("post_reset", now(), 32'd0);
`ifdef RTC_ALARM_EN
    press(1, 0);
    repeat (7) press(0, 1);
    press(1, 0);
    repeat (29) press(0, 1);
    press(1, 0);
    repeat (58) do_tick();
    chk("al_start", now(), tv(8'h07, 8'h29, 8'h58, 2'd0));
    do_tick();
    chk("al_low_0729", {31'd0, alarm}, 32'd0);
    clk_hz = 1'b1;
    repeat (3) cyc();
    chk("al_edge_0730", {31'd0, alarm}, 32'd0);
    cyc();
    chk("al_rise", {31'd0, alarm}, 32'd1);
    clk_hz = 1'b0;
    repeat (4) cyc();
    repeat (59) do_tick();
    chk("al_hold", {31'd0, alarm}, 32'd1);
    clk_hz = 1'b1;
    repeat (3) cyc();
    chk("al_edge_0731", now(), tv(8'h07, 8'h31, 8'h00, 2'd0));
    chk("al_still_hi", {31'd0, alarm}, 32'd1);
    cyc();
    chk("al_fall", {31'd0, alarm}, 32'd0);
    clk_hz = 1'b0;
    repeat (4) cyc();
    press(1, 0);
    press(1, 0);
    repeat (59) press(0, 1);
    press(1, 0);
    cyc();
    chk("al_rearm", {31'd0, alarm}, 32'd1);
    repeat (10) do_tick();
    btn_inc = 1'b1;
    cyc();
    btn_inc = 1'b0;
    chk("al_snooze", {31'd0, alarm}, 32'd0);
    repeat (3) do_tick();
    chk("al_snooze_hold", {31'd0, alarm}, 32'd0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
